// File: rtl/maze_navigator_if.sv
// Bundle between maze_navigator and its maze-memory/stack environment; master is the navigator side.
// moveCount is present only when MOVE_COUNT_EN is defined.
interface maze_navigator_if;
    logic       start;
    logic       memRead;
    logic       memWrite;
    logic [7:0] memAddr;
    logic       memDin;
    logic       memDout;
    logic       push;
    logic       pop;
    logic [3:0] xToStack;
    logic [3:0] yToStack;
    logic [3:0] xFromStack;
    logic [3:0] yFromStack;
    logic       stackFail;
    logic       busy;
    logic       done;
    logic       noPath;
    logic [3:0] xCur;
    logic [3:0] yCur;
`ifdef MOVE_COUNT_EN
    logic [15:0] moveCount;

    modport master (
        input  start, memDin, xFromStack, yFromStack, stackFail,
        output memRead, memWrite, memAddr, memDout, push, pop, xToStack, yToStack,
        output busy, done, noPath, xCur, yCur, moveCount
    );
    modport slave (
        output start, memDin, xFromStack, yFromStack, stackFail,
        input  memRead, memWrite, memAddr, memDout, push, pop, xToStack, yToStack,
        input  busy, done, noPath, xCur, yCur, moveCount
    );
`else
    modport master (
        input  start, memDin, xFromStack, yFromStack, stackFail,
        output memRead, memWrite, memAddr, memDout, push, pop, xToStack, yToStack,
        output busy, done, noPath, xCur, yCur
    );
    modport slave (
        output start, memDin, xFromStack, yFromStack, stackFail,
        input  memRead, memWrite, memAddr, memDout, push, pop, xToStack, yToStack,
        input  busy, done, noPath, xCur, yCur
    );
`endif
endinterface

// File: rtl/maze_navigator.sv
// Depth-first 16x16 maze walker over external maze memory and stack; MOVE_COUNT_EN adds a saturating moveCount.
// One state per memory/stack access, one-cycle read/pop latency; no backpressure, start ignored while busy.
module maze_navigator #(
    parameter logic [3:0] GOAL_X = 4'd15,
    parameter logic [3:0] GOAL_Y = 4'd15
) (
    input  logic             clk,
    input  logic             rst,
    maze_navigator_if.master nav
);
    typedef enum logic [3:0] {
        IDLE, CHECK, READ, WAITRD, MOVE, POP, POPWAIT, DONE, NOPATH
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic [2:0] dir_q, dir_d;
    logic [3:0] nbr_x, nbr_y;
    logic       nbr_ok, at_goal, idle_like, start_ok;

    assign idle_like = (state_q == IDLE) || (state_q == DONE) || (state_q == NOPATH);
    // start is masked by rst so outputs stay zero for the whole reset, even with start high
    assign start_ok  = idle_like && nav.start && !rst;
    assign at_goal   = (x_q == GOAL_X) && (y_q == GOAL_Y);

    always_comb begin
        nbr_x  = x_q;
        nbr_y  = y_q;
        nbr_ok = 1'b0;
        case (dir_q)
            3'd0: begin nbr_x = x_q + 4'd1; nbr_ok = (x_q != 4'd15); end
            3'd1: begin nbr_y = y_q + 4'd1; nbr_ok = (y_q != 4'd15); end
            3'd2: begin nbr_x = x_q - 4'd1; nbr_ok = (x_q != 4'd0);  end
            3'd3: begin nbr_y = y_q - 4'd1; nbr_ok = (y_q != 4'd0);  end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;
        nav.memRead  = 1'b0;
        nav.memWrite = 1'b0;
        nav.memAddr  = 8'h00;
        nav.memDout  = 1'b0;
        nav.push     = 1'b0;
        nav.pop      = 1'b0;
        nav.xToStack = 4'd0;
        nav.yToStack = 4'd0;
        nav.busy     = !idle_like;
        nav.done     = (state_q == DONE);
        nav.noPath   = (state_q == NOPATH);
        nav.xCur     = x_q;
        nav.yCur     = y_q;
        case (state_q)
            IDLE, DONE, NOPATH: begin
                if (start_ok) begin
                    nav.memWrite = 1'b1;
                    nav.memDout  = 1'b1;
                    x_d          = 4'd0;
                    y_d          = 4'd0;
                    dir_d        = 3'd0;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (at_goal)                state_d = DONE;
                else if (dir_q == 3'd4)     state_d = POP;
                else if (!nbr_ok)           dir_d   = dir_q + 3'd1;
                else                        state_d = READ;
            end
            READ: begin
                nav.memRead = 1'b1;
                nav.memAddr = {nbr_x, nbr_y};
                state_d     = WAITRD;
            end
            WAITRD: begin
                if (nav.memDin) begin
                    dir_d   = dir_q + 3'd1;
                    state_d = CHECK;
                end else begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                nav.push     = 1'b1;
                nav.xToStack = x_q;
                nav.yToStack = y_q;
                nav.memWrite = 1'b1;
                nav.memDout  = 1'b1;
                nav.memAddr  = {nbr_x, nbr_y};
                x_d          = nbr_x;
                y_d          = nbr_y;
                dir_d        = 3'd0;
                state_d      = CHECK;
            end
            POP: begin
                nav.pop = 1'b1;
                state_d = POPWAIT;
            end
            POPWAIT: begin
                if (nav.stackFail) begin
                    state_d = NOPATH;
                end else begin
                    x_d     = nav.xFromStack;
                    y_d     = nav.yFromStack;
                    dir_d   = 3'd0;
                    state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            dir_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
        end
    end

`ifdef MOVE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_ok)
            cnt_d = 16'd0;
        else if (((state_q == MOVE) || ((state_q == POPWAIT) && !nav.stackFail)) && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

    assign nav.moveCount = cnt_q;
`endif
endmodule

// File: doc/maze_navigator.md
MAZE_NAVIGATOR -- requirements
Module: maze_navigator

Interface
REQ-001 The block SHALL have parameter GOAL_X, default 4'd15, meaning the goal column.
REQ-002 The block SHALL have parameter GOAL_Y, default 4'd15, meaning the goal row.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit, a one-cycle request to begin a search; sampled only in IDLE.
REQ-006 The block SHALL have ports memRead and memWrite, output, 1 bit each, the maze memory strobes.
REQ-007 The block SHALL have port memAddr, output, 8 bits, the cell address {x[3:0], y[3:0]}.
REQ-008 The block SHALL have ports memDin, input, 1 bit, and memDout, output, 1 bit; memDin 1 means wall or visited, and memDout is the write data, always 1.
REQ-009 The block SHALL have ports push and pop, output, 1 bit each, the stack commands.
REQ-010 The block SHALL have ports xToStack and yToStack, output, 4 bits each, the coordinate being pushed.
REQ-011 The block SHALL have ports xFromStack, yFromStack (input, 4 bits each) and stackFail (input, 1 bit), the stack pop results, valid the cycle after pop.
REQ-012 The block SHALL have ports busy, done and noPath, output, 1 bit each, plus xCur and yCur, output, 4 bits each, the current cell.

Function
REQ-013 The block SHALL implement the states IDLE, CHECK, READ, WAITRD, MOVE, POP, POPWAIT, DONE and NOPATH.
REQ-014 On start in IDLE, the block SHALL set cur=(0,0) and dir=0, assert memWrite to address 8'h00 for one cycle (marking it visited), then enter CHECK.
REQ-015 In CHECK, if cur equals (GOAL_X,GOAL_Y), the block SHALL enter DONE; the goal test SHALL take priority over the direction scan.
REQ-016 The direction order SHALL be dir 0 right (x+1), 1 down (y+1), 2 left (x-1), 3 up (y-1).
REQ-017 In CHECK, a neighbour outside 0..15 SHALL be skipped: dir increments and the block stays in CHECK; there SHALL be no 4-bit wrap-around.
REQ-018 In CHECK with dir==4, the block SHALL enter POP.
REQ-019 In CHECK with an in-range neighbour, the block SHALL enter READ, where memRead=1 and memAddr=neighbour for exactly one cycle.
REQ-020 In WAITRD, memDin is valid (one-cycle read latency); if memDin==1, the block SHALL increment dir and enter CHECK, else it SHALL enter MOVE.
REQ-021 MOVE SHALL last one cycle, with push=1, {xToStack,yToStack}=cur, memWrite=1 and memAddr=neighbour; at the edge, cur becomes the neighbour, dir=0, and the next state is CHECK.
REQ-022 POP SHALL assert pop=1 for exactly one cycle, then enter POPWAIT.
REQ-023 In POPWAIT, if stackFail==1, the block SHALL enter NOPATH; otherwise cur={xFromStack,yFromStack}, dir=0, and the next state is CHECK.
REQ-024 push and pop SHALL never be asserted in the same cycle, and memRead and memWrite SHALL never be asserted in the same cycle.
REQ-025 busy SHALL be 1 in every state except IDLE, DONE and NOPATH.
REQ-026 done and noPath SHALL be held high in their states until the next start.
REQ-027 On start in DONE or NOPATH, the block SHALL clear the flag and restart as in REQ-014; maze and stack contents are the environment's responsibility.
REQ-028 start while busy SHALL be ignored.
REQ-029 All strobes and data outputs SHALL be 0 when not specified active.

Reset
REQ-030 While rst=1, the block SHALL be in IDLE, with cur=(0,0), dir=0, and all outputs 0, independent of clk.
REQ-031 rst asserted mid-search SHALL abort immediately, with no further push, pop or memory strobe after deassertion until a new start.

Configuration
REQ-032 With macro MOVE_COUNT_EN defined, the block SHALL add output moveCount, 16 bits, cleared by rst and by an accepted start, incremented once per push and once per successful (non-failing) pop, and saturating at 16'hFFFF.
REQ-033 Without MOVE_COUNT_EN, the moveCount port and its counter SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-034 Bench scenario: all cells open except row 0 walls at x>=1, GOAL=(0,1) -> done after path (0,0)->(0,1); exactly 1 push of (0,0); moveCount=1.
REQ-035 Bench scenario: cell (1,0) and (0,1) both walls -> dir scan exhausts, 1 pop, stackFail=1 -> noPath=1, done=0, busy=0.
REQ-036 Bench scenario: dead-end corridor (1,0) open, (2,0),(1,1) walls, (0,1) open, goal (0,2) -> push (0,0), pop returning (0,0), push (0,0), push (0,1), done; moveCount=4.
REQ-037 Bench scenario: at cur=(15,y), dir 0 -> no memRead issued for x=0 (no wrap); check memAddr never equals {4'h0,y} in that cycle.
REQ-038 Bench scenario: rst pulsed during MOVE -> push observed at most that cycle, outputs 0 within the reset, IDLE held; then start -> search restarts at (0,0).
REQ-039 Bench scenario: start pulsed while busy -> no state change; start while done=1 -> done falls next cycle and memWrite to 8'h00 is seen.
